// File: rtl/frame_rcvr.sv
// Serial frame receiver.
// Hunts a serial bit stream for an HDR_W-bit header pattern (MSB first), then
// captures the following DATA_W bits as one frame body and pushes it into a
// DEPTH-entry first-word-fall-through FIFO. Reception never stalls: a frame
// that completes while the FIFO is full (and not being popped) is dropped and
// flagged on overrun.
//
// Ports:
//   clock     sole clock, rising edge
//   reset     synchronous, active-high reset
//   data_in   serial input, one bit per clock, MSB first
//   reading   pop request for the head frame (ignored while ready=0);
//             also clears overrun
//   ready     registered, FIFO holds at least one frame
//   overrun   registered, a completed frame was dropped since the last read
//   data_out  head FIFO entry, valid while ready=1
//   count     registered, number of frames held
module frame_rcvr #(
   parameter int unsigned      HDR_W  = 8,
   parameter logic [HDR_W-1:0] MATCH  = HDR_W'(8'hA5),
   parameter int unsigned      DATA_W = 8,
   parameter int unsigned      DEPTH  = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       data_in,
   input  logic                       reading,
   output logic                       ready,
   output logic                       overrun,
   output logic [DATA_W-1:0]          data_out,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned HC_W  = $clog2(HDR_W + 1);
   localparam int unsigned BC_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic {
      HUNT = 1'b0,
      BODY = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   state_t               state_q;
   state_t               state_d;

   logic [HDR_W-2:0]     win_q;        // previous HDR_W-1 hunt bits
   logic [HC_W-1:0]      hdr_cnt_q;    // hunt bits seen since entering HUNT
   logic [BC_W-1:0]      bit_cnt_q;    // body bit index
   logic [DATA_W-1:0]    body_q;

   logic [DATA_W-1:0]    mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [CNT_W-1:0]     count_q;
   logic                 ready_q;
   logic                 overrun_q;

   logic [HDR_W-1:0]     hdr_next_c;
   logic                 hdr_full_c;
   logic                 hdr_hit_c;
   logic [DATA_W-1:0]    body_next_c;
   logic                 body_last_c;

   logic                 push_c;
   logic                 pop_c;
   logic                 full_c;
   logic                 store_c;
   logic                 drop_c;
   logic [CNT_W-1:0]     count_d;

   // ------------------------------------------------------------------
   // Receive datapath helpers
   // ------------------------------------------------------------------
   // Candidate header includes the bit arriving this cycle, so a match is
   // seen on the same edge that samples the header's last bit.
   assign hdr_next_c  = {win_q, data_in};
   assign hdr_full_c  = (hdr_cnt_q >= HC_W'(HDR_W - 1));
   assign hdr_hit_c   = hdr_full_c && (hdr_next_c == MATCH);
   // Cast drops the oldest bit; this also covers DATA_W == 1.
   assign body_next_c = DATA_W'({body_q, data_in});
   assign body_last_c = (bit_cnt_q == BC_W'(DATA_W - 1));

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         HUNT: begin
            if (hdr_hit_c) begin
               state_d = BODY;
            end
         end
         BODY: begin
            if (body_last_c) begin
               state_d = HUNT;
            end
         end
         default: begin
            state_d = HUNT;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs / FIFO control decode
   // ------------------------------------------------------------------
   always_comb begin
      push_c  = 1'b0;
      pop_c   = 1'b0;
      full_c  = 1'b0;
      store_c = 1'b0;
      drop_c  = 1'b0;
      count_d = count_q;

      push_c  = (state_q == BODY) && body_last_c;
      pop_c   = reading && ready_q;
      full_c  = (count_q == CNT_W'(DEPTH));
      // A pop on a full FIFO frees the slot the push is about to use.
      store_c = push_c && (!full_c || pop_c);
      drop_c  = push_c && full_c && !pop_c;
      count_d = count_q + CNT_W'(store_c) - CNT_W'(pop_c);
   end

   // ------------------------------------------------------------------
   // Header / body counters (reset to known values)
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         hdr_cnt_q <= '0;
         bit_cnt_q <= '0;
      end else begin
         case (state_q)
            HUNT: begin
               bit_cnt_q <= '0;
               if (hdr_cnt_q != HC_W'(HDR_W)) begin
                  hdr_cnt_q <= hdr_cnt_q + HC_W'(1);
               end
            end
            BODY: begin
               // Cleared while in BODY so every return to HUNT starts at 0
               // and body bits can never complete a header.
               hdr_cnt_q <= '0;
               if (body_last_c) begin
                  bit_cnt_q <= '0;
               end else begin
                  bit_cnt_q <= bit_cnt_q + BC_W'(1);
               end
            end
            default: begin
               hdr_cnt_q <= '0;
               bit_cnt_q <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Shift registers (no reset needed; contents qualified by counters)
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (state_q == HUNT) begin
         win_q <= hdr_next_c[HDR_W-2:0];
      end
      if (state_q == BODY) begin
         body_q <= body_next_c;
      end
   end

   // ------------------------------------------------------------------
   // FIFO storage
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset && store_c) begin
         mem[wr_ptr_q] <= body_next_c;
      end
   end

   // ------------------------------------------------------------------
   // FIFO pointers, occupancy and status flags
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ready_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (store_c) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
         ready_q <= (count_d != '0);
         // Any read clears the flag, and the clear wins over a new drop.
         if (reading) begin
            overrun_q <= 1'b0;
         end else if (drop_c) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign ready    = ready_q;
   assign overrun  = overrun_q;
   assign count    = count_q;
   assign data_out = mem[rd_ptr_q];

endmodule

// File: doc/frame_rcvr.md
FRAME_RCVR -- requirements
Module: frame_rcvr

Interface
REQ-001 Parameter HDR_W, default 8, header length in bits (2..16).
REQ-002 Parameter MATCH, default 8'hA5, header pattern (HDR_W bits), MSB first.
REQ-003 Parameter DATA_W, default 8, body length in bits (1..32).
REQ-004 Parameter DEPTH, default 4, frame FIFO entries (power of 2, >=2).
REQ-005 clock  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  1  serial bit stream, one bit per clock, MSB first.
REQ-008 reading  input  1  pop request for head frame; ignored when ready=0.
REQ-009 ready  output  1  registered; FIFO non-empty.
REQ-010 overrun  output  1  registered; a completed frame was dropped since last pop.
REQ-011 data_out  output  DATA_W  head FIFO entry (first-word fall-through); undefined while ready=0.
REQ-012 count  output  $clog2(DEPTH)+1  registered; number of frames held.

Function
REQ-013 Two-state FSM: HUNT, BODY; reset state HUNT.
REQ-014 HUNT: shift data_in into HDR_W-bit window; also count bits since entering HUNT, saturating at HDR_W.
REQ-015 HUNT -> BODY when bit count reaches HDR_W including the current bit and {window, data_in} == MATCH; overlapping header candidates (e.g. 0xA5 inside 0x4A5) are detected.
REQ-016 On every entry to HUNT (reset or end of body) the window bit count clears to 0; bits from a previous body never contribute to a header match.
REQ-017 BODY: shift data_in into DATA_W-bit body register for exactly DATA_W cycles (bit counter 0..DATA_W-1), then -> HUNT.
REQ-018 Timing: header last bit sampled at edge t; body bits at t+1..t+DATA_W; frame pushed and visible on data_out/ready after edge t+DATA_W; first hunt bit at edge t+DATA_W+1.
REQ-019 Push occurs on the final body cycle, value {body_reg[DATA_W-2:0], data_in}.
REQ-020 Pop occurs when reading=1 and ready=1; next head appears on data_out the following cycle.
REQ-021 Push when count<DEPTH: frame stored, count+1 (unless simultaneous pop: count unchanged).
REQ-022 Push when count==DEPTH with simultaneous pop: both succeed, count stays DEPTH, no overrun.
REQ-023 Push when count==DEPTH without pop: frame dropped, FIFO unchanged, overrun<=1.
REQ-024 overrun clears on any cycle with reading=1 (pop or not); clear has priority over set in the same cycle.
REQ-025 reading while empty: no state change except overrun clear; count never underflows.
REQ-026 FIFO pointers wrap modulo DEPTH; count distinguishes full from empty.
REQ-027 FSM progression is independent of FIFO state and reading; reception never stalls.

Reset
REQ-028 reset=1 at an edge: FSM->HUNT, window count=0, body counter=0, FIFO pointers=0, count=0, ready=0, overrun=0; data registers need not reset.
REQ-029 Reset mid-body discards the partial frame; no push occurs.
REQ-030 Reset dominates all simultaneous push, pop, and header-match events.

Verification
REQ-031 Defaults; stream 1010_0101 then 0011_1100 -> after last body bit edge ready=1, data_out=8'h3C, count=1.
REQ-032 Stream 0100_1010_0101 then body 8'hFF -> overlapping header detected, data_out=8'hFF; stream 1010_0100 then 8 bits -> no frame.
REQ-033 Body 8'hA5 immediately followed by 8'h77 -> the 8'h77 is not framed; next valid header plus body 8'h11 -> single push of 8'h11.
REQ-034 Five frames 8'h01..8'h05 with no reading -> count=4, overrun=1 after fifth; pop four times -> 8'h01..8'h04 in order; overrun=0 after first pop.
REQ-035 FIFO full, reading=1 on fifth frame's completing cycle -> count stays 4, overrun=0, head order 8'h02..8'h05.
REQ-036 reset asserted at body bit 4 -> count=0, ready=0; subsequent full frame 8'h5A received correctly.
